// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Command-driven controller for an external bank of WIDTH JK flip-flops that
//   shares CLK. A host command (CLEAR, SET, LOAD, COUNT_UP, COUNT_DOWN, TOGGLE,
//   NOP) is accepted in IDLE, executed in EXEC by driving per-bit J/K vectors
//   (using the bank's Q outputs as feedback when counting), and acknowledged
//   by a one-cycle DONE pulse in FIN.
//
// Ports
//   CLK        rising-edge clock, shared with the bank
//   RESET_N    asynchronous reset, active low
//   CMD_VALID  command present
//   CMD_READY  command accepted this cycle when also CMD_VALID
//   CMD_OP     0 CLEAR, 1 SET, 2 LOAD, 3 COUNT_UP, 4 COUNT_DOWN, 5 TOGGLE, 6-7 NOP
//   CMD_DATA   load value (LOAD only)
//   CMD_LEN    number of count steps (COUNT_UP/DOWN only), 0 = none
//   ABORT      synchronous abort of the current command
//   Q_IN       bank Q outputs
//   J, K       bank J/K inputs
//   BUSY       controller not idle
//   DONE       one-cycle pulse on normal completion
//   SAT        last count command stopped at a boundary (SATURATE=1 only)
module jk_bank_sequencer #(
  parameter int WIDTH    = 4,
  parameter int LEN_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] Q_IN,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             SAT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_UP     = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_TOGGLE = 3'd5;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic             sat_reg, sat_next;

  logic [WIDTH-1:0] j_drive, k_drive;
  logic             done_drive;
  logic             accept;
  logic             new_is_count;
  logic             at_bound;

  // Toggle masks of a ripple counter: bit i flips when all lower bits are 1
  // (up) or all lower bits are 0 (down).
  logic [WIDTH-1:0] t_up, t_down;

  assign t_up[0]   = 1'b1;
  assign t_down[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tmask
      assign t_up[gi]   = t_up[gi-1]   &  Q_IN[gi-1];
      assign t_down[gi] = t_down[gi-1] & ~Q_IN[gi-1];
    end
  endgenerate

  assign CMD_READY    = (state_reg == ST_IDLE) & ~ABORT;
  assign accept       = CMD_VALID & CMD_READY;
  assign new_is_count = (CMD_OP == OP_UP) || (CMD_OP == OP_DOWN);

  // Boundary test is only meaningful while a count command is executing.
  assign at_bound = (SATURATE != 0) &&
                    ((op_reg == OP_UP) ? (&Q_IN) : ~(|Q_IN));

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    sat_next   = sat_reg;
    j_drive    = '0;
    k_drive    = '0;
    done_drive = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next   = CMD_OP;
          data_next = CMD_DATA;
          rem_next  = CMD_LEN;
          sat_next  = 1'b0;
          // Zero-length counts and NOPs have nothing to drive: skip EXEC.
          if ((new_is_count && (CMD_LEN == '0)) || (CMD_OP >= 3'd6)) begin
            state_next = ST_FIN;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (ABORT) begin
          state_next = ST_IDLE;
        end else begin
          case (op_reg)
            OP_CLEAR: begin
              k_drive    = '1;
              state_next = ST_FIN;
            end
            OP_SET: begin
              j_drive    = '1;
              state_next = ST_FIN;
            end
            OP_LOAD: begin
              j_drive    = data_reg;
              k_drive    = ~data_reg;
              state_next = ST_FIN;
            end
            OP_TOGGLE: begin
              j_drive    = '1;
              k_drive    = '1;
              state_next = ST_FIN;
            end
            OP_UP, OP_DOWN: begin
              if (at_bound) begin
                // Hold the bank and stop; this cycle is not a counted step.
                sat_next   = 1'b1;
                state_next = ST_FIN;
              end else begin
                j_drive  = (op_reg == OP_UP) ? t_up : t_down;
                k_drive  = j_drive;
                rem_next = rem_reg - LEN_W'(1);
                if (rem_reg == LEN_W'(1)) begin
                  state_next = ST_FIN;
                end
              end
            end
            default: begin
              state_next = ST_FIN;
            end
          endcase
        end
      end

      ST_FIN: begin
        done_drive = ~ABORT;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      data_reg  <= '0;
      rem_reg   <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      sat_reg   <= sat_next;
    end
  end

  assign J    = j_drive;
  assign K    = k_drive;
  assign BUSY = (state_reg != ST_IDLE);
  assign DONE = done_drive;
  assign SAT  = sat_reg;

endmodule
